// File: rtl/mem_cmd_sequencer.sv
// rtl/mem_cmd_sequencer.sv - command FIFO feeding a single-port memory with read timeout
module mem_cmd_sequencer #(
    parameter int Depth      = 4,
    parameter int Data_width = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [Depth-1:0]      cmd_add,
    input  logic [Data_width-1:0] cmd_data,
    output logic                  EN,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [Depth-1:0]      add,
    output logic [Data_width-1:0] Data_in,
    input  logic                  valid_out,
    input  logic [Data_width-1:0] Data_out,
    output logic                  rsp_valid,
    output logic [Depth-1:0]      rsp_add,
    output logic [Data_width-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  fifo_wr   [4];
    logic [Depth-1:0]      fifo_add  [4];
    logic [Data_width-1:0] fifo_data [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            count;
    logic                  push, pop;

    logic [TW-1:0]         timer, timer_nxt;
    logic                  en_nxt, wr_en_nxt, rd_en_nxt;
    logic [Depth-1:0]      add_nxt;
    logic [Data_width-1:0] data_in_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt;
    logic [Depth-1:0]      rsp_add_nxt;
    logic [Data_width-1:0] rsp_data_nxt;

    // Readiness comes only from the registered count, so a pop never frees a slot early
    assign cmd_ready = (count != 3'd4);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count != 3'd0) || (state != IDLE);

    // FIFO storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]   <= cmd_wr;
            fifo_add[wr_ptr]  <= cmd_add;
            fifo_data[wr_ptr] <= cmd_data;
        end
    end

    // Sequencer next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        timer_nxt     = timer;
        en_nxt        = 1'b0;
        wr_en_nxt     = 1'b0;
        rd_en_nxt     = 1'b0;
        add_nxt       = add;
        data_in_nxt   = Data_in;
        rsp_valid_nxt = 1'b0;
        rsp_add_nxt   = rsp_add;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop         = 1'b1;
                    state_nxt   = ISSUE;
                    en_nxt      = 1'b1;
                    wr_en_nxt   = fifo_wr[rd_ptr];
                    rd_en_nxt   = !fifo_wr[rd_ptr];
                    add_nxt     = fifo_add[rd_ptr];
                    data_in_nxt = fifo_data[rd_ptr];
                end
            end
            ISSUE: begin
                timer_nxt = '0;
                state_nxt = wr_en ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (valid_out) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_add_nxt   = add;
                    rsp_data_nxt  = Data_out;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_add_nxt   = add;
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, FIFO bookkeeping and registered memory/response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            timer     <= '0;
            EN        <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            add       <= '0;
            Data_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_add   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count     <= count + {2'b00, push} - {2'b00, pop};
            timer     <= timer_nxt;
            EN        <= en_nxt;
            wr_en     <= wr_en_nxt;
            rd_en     <= rd_en_nxt;
            add       <= add_nxt;
            Data_in   <= data_in_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_add   <= rsp_add_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// tb/tb_mem_cmd_sequencer.sv - randomized and directed bench for mem_cmd_sequencer
module tb_mem_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_wr;
    logic [DEPTH-1:0] cmd_add;
    logic [DW-1:0]    cmd_data;
    logic             EN, wr_en, rd_en;
    logic [DEPTH-1:0] add;
    logic [DW-1:0]    Data_in;
    logic             valid_out;
    logic [DW-1:0]    Data_out;
    logic             rsp_valid;
    logic [DEPTH-1:0] rsp_add;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    mem_cmd_sequencer #(.Depth(DEPTH), .Data_width(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_add(cmd_add), .cmd_data(cmd_data),
        .EN(EN), .wr_en(wr_en), .rd_en(rd_en), .add(add), .Data_in(Data_in),
        .valid_out(valid_out), .Data_out(Data_out),
        .rsp_valid(rsp_valid), .rsp_add(rsp_add), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct {
        logic             wr;
        logic [DEPTH-1:0] add;
        logic [DW-1:0]    data;
    } cmd_t;

    // Reference: pending-command queue plus issue/response timing in edge numbers
    cmd_t             q[$];
    int               edge_n, free_edge, rd_issue;
    bit               rd_active, m_acc;
    logic [DEPTH-1:0] rd_add;
    logic             m_ready, m_en, m_wr, m_rd, m_busy, m_rsp_valid, m_rsp_err;
    logic [DEPTH-1:0] m_add, m_rsp_add;
    logic [DW-1:0]    m_din, m_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        edge_n = 0; free_edge = 0; rd_issue = 0; rd_active = 0; m_acc = 0; rd_add = '0;
        m_ready = 1; m_en = 0; m_wr = 0; m_rd = 0; m_busy = 0;
        m_add = '0; m_din = '0; m_rsp_valid = 0; m_rsp_add = '0; m_rsp_data = '0; m_rsp_err = 0;
    endtask

    // Advance the reference across one rising edge given the inputs of the cycle before it
    task automatic model_edge(input logic v, input logic w, input logic [DEPTH-1:0] a,
                              input logic [DW-1:0] d, input logic vo, input logic [DW-1:0] dout);
        int   e;
        int   sz;
        bit   was_rd;
        cmd_t c;
        e      = edge_n + 1;
        sz     = q.size();
        was_rd = rd_active;
        m_acc  = v && (sz < 4);
        m_en = 0; m_wr = 0; m_rd = 0; m_rsp_valid = 0;
        if (was_rd && e >= rd_issue + 2) begin
            if (vo || e == rd_issue + 1 + TIMEOUT) begin
                m_rsp_valid = 1;
                m_rsp_add   = rd_add;
                m_rsp_data  = vo ? dout : '0;
                m_rsp_err   = !vo;
                rd_active   = 0;
                free_edge   = e + 1;
            end
        end else if (!was_rd && sz > 0 && e >= free_edge) begin
            c     = q.pop_front();
            m_en  = 1;
            m_wr  = c.wr;
            m_rd  = !c.wr;
            m_add = c.add;
            m_din = c.data;
            if (c.wr) begin
                free_edge = e + 2;
            end else begin
                rd_active = 1;
                rd_issue  = e;
                rd_add    = c.add;
            end
        end
        if (m_acc) q.push_back('{wr: w, add: a, data: d});
        m_ready = (q.size() < 4);
        m_busy  = (q.size() != 0) || m_en || rd_active;
        edge_n  = e;
    endtask

    task automatic check_outputs();
        chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
        chk("EN",        64'(EN),        64'(m_en));
        chk("wr_en",     64'(wr_en),     64'(m_wr));
        chk("rd_en",     64'(rd_en),     64'(m_rd));
        chk("add",       64'(add),       64'(m_add));
        chk("Data_in",   64'(Data_in),   64'(m_din));
        chk("busy",      64'(busy),      64'(m_busy));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        chk("rsp_add",   64'(rsp_add),   64'(m_rsp_add));
        chk("rsp_data",  64'(rsp_data),  64'(m_rsp_data));
        chk("rsp_err",   64'(rsp_err),   64'(m_rsp_err));
    endtask

    // Called on a falling edge: check this cycle, then drive the inputs for the next edge
    task automatic step(input logic v, input logic w, input logic [DEPTH-1:0] a,
                        input logic [DW-1:0] d, input logic vo, input logic [DW-1:0] dout);
        check_outputs();
        model_edge(v, w, a, d, vo, dout);
        cmd_valid = v; cmd_wr = w; cmd_add = a; cmd_data = d;
        valid_out = vo; Data_out = dout;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic vo);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, vo, 32'h5A5A_0000 + 32'(i));
    endtask

    task automatic send(input logic w, input logic [DEPTH-1:0] a, input logic [DW-1:0] d);
        int g;
        g = 0;
        do begin
            step(1, w, a, d, 0, '0);
            g++;
        end while (!m_acc && g < 40);
        if (!m_acc) chk("send_accept_bound", 64'(m_acc), 64'd1);
    endtask

    task automatic wait_rd_issue();
        int g;
        g = 0;
        while (!m_rd && g < 40) begin
            step(0, 0, '0, '0, 0, '0);
            g++;
        end
        if (!m_rd) chk("rd_issue_bound", 64'(m_rd), 64'd1);
    endtask

    task automatic apply_reset();
        cmd_valid = 0; cmd_wr = 0; cmd_add = '0; cmd_data = '0; valid_out = 0; Data_out = '0;
        rst = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        valid_out = 1; Data_out = 32'hBAD0_BAD0;
        @(negedge clk);
        check_outputs();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        cmd_valid = 0; cmd_wr = 0; cmd_add = '0; cmd_data = '0; valid_out = 0; Data_out = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1;

        // Single write, then read answered two cycles after rd_en
        send(1, 4'd3, 32'hDEAD_BEEF);
        idle(3, 0);
        send(0, 4'd3, 32'h0);
        wait_rd_issue();
        idle(2, 0);
        step(0, 0, '0, '0, 1, 32'hDEAD_BEEF);
        idle(2, 0);

        // Five back-to-back reads with the memory silent: FIFO fills, all time out in order
        for (int i = 0; i < 5; i++) send(0, 4'(i + 8), 32'(i));
        idle(60, 0);

        // Timeout followed by a write that must still issue
        send(0, 4'd7, '0);
        send(1, 4'd9, 32'h1234_5678);
        idle(16, 0);

        // Spurious valid_out while idle
        idle(4, 1);

        // Reset while waiting on a read with two commands queued, then a late valid_out
        send(0, 4'd5, '0);
        send(1, 4'd6, 32'hAAAA_5555);
        send(1, 4'd2, 32'h5555_AAAA);
        idle(2, 0);
        apply_reset();
        idle(4, 1);
        idle(2, 0);

        // Randomized traffic with occasional memory responses
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 45, 1'($urandom), 4'($urandom), $urandom,
                 $urandom_range(0, 99) < 12, $urandom);
            if (i == 400) apply_reset();
        end
        idle(20, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
